// File: rtl/vga_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_capture : VGA bus monitor rebuilding framebuffer pixels and checking  |
// |               line/frame timing.                 Revision 1.0             |
// +--------------------------------------------------------------------------+
module vga_capture #(
    parameter string RESOLUTION    = "640x480",
    parameter int    CHANNEL_SIZES = 8,
    parameter int    H_TOTAL       = 800,
    parameter int    V_TOTAL       = 525,
    parameter int    H_ACTIVE      = 640,
    parameter int    V_ACTIVE      = 480,
    parameter int    XW            = (RESOLUTION == "160x120") ? 8 :
                                     (RESOLUTION == "320x240") ? 9 : 10,
    parameter int    YW            = ((RESOLUTION == "160x120") ||
                                      (RESOLUTION == "320x240")) ? 8 : 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_ce,
    input  logic [7:0]               vga_r,
    input  logic [7:0]               vga_g,
    input  logic [7:0]               vga_b,
    input  logic                     vga_hs,
    input  logic                     vga_vs,
    input  logic                     vga_blank_n,
    output logic                     px_valid,
    output logic [XW-1:0]            px_x,
    output logic [YW-1:0]            px_y,
    output logic [CHANNEL_SIZES-1:0] px_r,
    output logic [CHANNEL_SIZES-1:0] px_g,
    output logic [CHANNEL_SIZES-1:0] px_b,
    output logic                     sof,
    output logic                     eof,
    output logic                     locked,
    output logic [15:0]              frame_cnt,
    output logic                     line_err,
    output logic                     frame_err,
    output logic                     act_err
);

    localparam int S  = (RESOLUTION == "160x120") ? 2 :
                        (RESOLUTION == "320x240") ? 1 : 0;
    localparam int CW = 11;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] COL_END = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] ROW_END = CW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          prev_hs;
    logic          prev_vs;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          h_armed;
    logic          err_pend;

    logic hs_fall;
    logic vs_fall;
    logic line_err_now;
    logic frame_err_now;
    logic act_err_now;
    logic any_err;
    logic pix_ok;

    // Every event is qualified by pix_ce so state only moves on sample cycles.
    always_comb begin
        hs_fall       = pix_ce & prev_hs & ~vga_hs;
        vs_fall       = pix_ce & prev_vs & ~vga_vs;
        line_err_now  = hs_fall & h_armed & (h_cnt != H_LAST);
        frame_err_now = vs_fall & (state != SEARCH) & (v_cnt != V_LAST);
        act_err_now   = pix_ce & vga_blank_n & ((col >= H_ACT) | (row >= V_ACT));
        any_err       = line_err_now | frame_err_now | act_err_now;
        pix_ok        = pix_ce & (state == LOCKED) & vga_blank_n & ~act_err_now;
    end

    // err_pend remembers any error since the last vs_fall, so a lock needs
    // one complete clean frame bounded by two vs_falls.
    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: if (vs_fall) state_nxt = ALIGN;
            ALIGN:  if (vs_fall && !err_pend && !any_err) state_nxt = LOCKED;
            LOCKED: if (any_err) state_nxt = ALIGN;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_hs  <= 1'b1;
            prev_vs  <= 1'b1;
            h_cnt    <= '0;
            v_cnt    <= '0;
            col      <= '0;
            row      <= '0;
            h_armed  <= 1'b0;
            err_pend <= 1'b0;
        end else if (pix_ce) begin
            prev_hs <= vga_hs;
            prev_vs <= vga_vs;

            if (hs_fall)
                h_cnt <= '0;
            else if (h_cnt != CNT_MAX)
                h_cnt <= h_cnt + 1'b1;

            if (vs_fall)
                v_cnt <= '0;
            else if (hs_fall && (v_cnt != CNT_MAX))
                v_cnt <= v_cnt + 1'b1;

            if (hs_fall)
                col <= '0;
            else if (vga_blank_n && (col != CNT_MAX))
                col <= col + 1'b1;

            if (vs_fall)
                row <= '0;
            else if (hs_fall && (col != '0) && (row != CNT_MAX))
                row <= row + 1'b1;

            // The first line after reset starts from an unknown phase.
            if (hs_fall)
                h_armed <= 1'b1;

            if (vs_fall)
                err_pend <= 1'b0;
            else if (any_err)
                err_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_valid  <= 1'b0;
            px_x      <= '0;
            px_y      <= '0;
            px_r      <= '0;
            px_g      <= '0;
            px_b      <= '0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            frame_cnt <= '0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            act_err   <= 1'b0;
        end else begin
            px_valid  <= pix_ok;
            sof       <= pix_ok & (col == '0) & (row == '0);
            eof       <= pix_ok & (col == COL_END) & (row == ROW_END);
            line_err  <= line_err_now;
            frame_err <= frame_err_now;
            act_err   <= act_err_now;
            if (pix_ok) begin
                px_x <= XW'(col >> S);
                px_y <= YW'(row >> S);
                px_r <= vga_r[7 -: CHANNEL_SIZES];
                px_g <= vga_g[7 -: CHANNEL_SIZES];
                px_b <= vga_b[7 -: CHANNEL_SIZES];
            end
            if (vs_fall && (state == LOCKED) && !frame_err_now)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign locked = (state == LOCKED);

endmodule
`default_nettype wire
